// File: rtl/uart_word_tx.sv
// Serialises one 32-bit ASCII status word per handshake as UART 8N1 frames,
// most significant byte first, optionally followed by CR LF.
module uart_word_tx #(
    parameter int CLK_FREQ    = 27000000,
    parameter int BAUD        = 115200,
    parameter int APPEND_CRLF = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] words_sent,
    output logic [1:0]  dbg_state
);
    // Handshake: a word is taken on a posedge where word_valid && word_ready;
    // word_ready is high only in IDLE, and word_in is ignored at all other times.

    // CLKS_PER_BIT must be at least 2 for the baud counter to be meaningful.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BYTE = (APPEND_CRLF != 0) ? 3'd5 : 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_tx;
    logic          r_ready;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [2:0]    r_byte_idx;
    logic [31:0]   r_word;
    logic [15:0]   r_words_sent;

    logic [7:0]    w_cur_byte;
    logic [2:0]    w_next_bit;
    logic          w_bit_end;

    always_comb begin
        w_cur_byte = 8'h00;
        case (r_byte_idx)
            3'd0:    w_cur_byte = r_word[31:24];
            3'd1:    w_cur_byte = r_word[23:16];
            3'd2:    w_cur_byte = r_word[15:8];
            3'd3:    w_cur_byte = r_word[7:0];
            3'd4:    w_cur_byte = 8'h0D;
            3'd5:    w_cur_byte = 8'h0A;
            default: w_cur_byte = 8'h00;
        endcase
    end

    assign w_next_bit = r_bit_idx + 3'd1;
    assign w_bit_end  = (r_baud == BAUD_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_tx         <= 1'b1;
            r_ready      <= 1'b1;
            r_baud       <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_words_sent <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (word_valid && r_ready) begin
                        r_word     <= word_in;
                        r_byte_idx <= '0;
                        r_baud     <= '0;
                        r_tx       <= 1'b0;
                        r_ready    <= 1'b0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= w_next_bit;
                            r_tx      <= w_cur_byte[w_next_bit];
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        // Next byte's start bit follows the stop bit with no idle gap.
                        if (r_byte_idx < LAST_BYTE) begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else begin
                            r_words_sent <= r_words_sent + 16'd1;
                            r_ready      <= 1'b1;
                            r_state      <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign word_ready = r_ready;
    assign busy       = ~r_ready;
    assign uart_tx    = r_tx;
    assign words_sent = r_words_sent;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_word_tx.sv
// Randomised scoreboard bench for uart_word_tx: two instances (word only and
// word + CR LF) exercised in turn, with a line decoder monitor per instance.
module tb_uart_word_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] win [2];
  logic [1:0] valid;
  logic [1:0] ready;
  logic [1:0] tx;
  logic [1:0] busy;
  logic [15:0] ws [2];
  logic [1:0] st [2];

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int exp_ws [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_word_tx #(.CLK_FREQ(40), .BAUD(10), .APPEND_CRLF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .word_in(win[0]), .word_valid(valid[0]),
    .word_ready(ready[0]), .uart_tx(tx[0]), .busy(busy[0]),
    .words_sent(ws[0]), .dbg_state(st[0])
  );

  uart_word_tx #(.CLK_FREQ(40), .BAUD(10), .APPEND_CRLF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .word_in(win[1]), .word_valid(valid[1]),
    .word_ready(ready[1]), .uart_tx(tx[1]), .busy(busy[1]),
    .words_sent(ws[1]), .dbg_state(st[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int nbytes(input int i);
    return (i == 0) ? 4 : 6;
  endfunction

  // Reference model: byte order on the line, flag marks the first byte of a word.
  task automatic push_word(input int i, input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 0), w[31-8*k -: 8]});
    if (i == 1) begin
      exp_q.push_back({1'b0, 8'h0D});
      exp_q.push_back({1'b0, 8'h0A});
    end
  endtask

  // Line decoder: every bit must hold its level for exactly CPB cycles.
  task automatic mon(input int i);
    int gap;
    int n;
    logic lvl;
    logic ok;
    logic ab;
    logic [9:0] fr;
    logic [8:0] e;
    gap = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin gap = 0; continue; end
      if (tx[i]) begin gap++; continue; end
      fr = '0; ok = 1'b1; ab = 1'b0; n = 0; lvl = 1'b0;
      while (n < 10*CPB) begin
        if (n > 0) begin
          @(negedge clk);
          if (!rst_n) begin ab = 1'b1; break; end
        end
        if (n % CPB == 0) begin
          lvl = tx[i];
          fr[n/CPB] = lvl;
        end else if (tx[i] !== lvl) begin
          ok = 1'b0;
        end
        n++;
      end
      if (ab) begin gap = 0; continue; end
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame dut%0d: byte %0h with nothing expected", i, fr[8:1]);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("frame_byte_dut%0d", i), fr[8:1], e[7:0]);
        check($sformatf("frame_shape_dut%0d", i), {ok, fr[0], fr[9]}, 3'b101);
        if (!e[8]) check($sformatf("byte_gap_dut%0d", i), gap, 0);
      end
      gap = 0;
    end
  endtask

  task automatic accept(input int i, input logic [31:0] w, output int t_acc);
    int k;
    k = 0;
    @(negedge clk);
    win[i] = w;
    valid[i] = 1'b1;
    while (!ready[i] && k < 2000) begin @(negedge clk); k++; end
    check("accept_timeout", (k < 2000), 1);
    t_acc = cyc + 1;
    push_word(i, w);
    @(posedge clk);
  endtask

  task automatic wait_ready(input int i);
    int k;
    k = 0;
    while (!ready[i] && k < 5000) begin @(negedge clk); k++; end
    check("ready_timeout", (k < 5000), 1);
  endtask

  task automatic send(input int i, input logic [31:0] w, input bit disturb);
    int t;
    accept(i, w, t);
    @(negedge clk);
    valid[i] = 1'b0;
    if (disturb) begin
      repeat (CPB*7) @(negedge clk);
      win[i] = 32'hFFFF_FFFF;
      valid[i] = 1'b1;
      check("ready_low_while_busy", ready[i], 0);
      repeat (3) @(negedge clk);
      valid[i] = 1'b0;
      win[i] = $urandom;
    end
    wait_ready(i);
    check("done_latency", cyc - t, 10*CPB*nbytes(i));
    exp_ws[i]++;
    check("words_sent", ws[i], exp_ws[i] & 32'hFFFF);
    check("busy_low", busy[i], 0);
    check("state_idle", st[i], 0);
    check("line_idle", tx[i], 1);
  endtask

  task automatic burst(input int i, input int n);
    int t_prev;
    int t;
    accept(i, $urandom, t_prev);
    for (int j = 1; j < n; j++) begin
      accept(i, $urandom, t);
      check("b2b_spacing", t - t_prev, 10*CPB*nbytes(i) + 1);
      exp_ws[i]++;
      check("b2b_words_sent", ws[i], exp_ws[i] & 32'hFFFF);
      t_prev = t;
    end
    @(negedge clk);
    valid[i] = 1'b0;
    wait_ready(i);
    exp_ws[i]++;
    check("b2b_final_count", ws[i], exp_ws[i] & 32'hFFFF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    valid = 2'b00;
    win[0] = '0;
    win[1] = '0;
    exp_ws[0] = 0;
    exp_ws[1] = 0;
    fork
      mon(0);
      mon(1);
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_tx", tx[i], 1);
      check("rst_ready", ready[i], 1);
      check("rst_busy", busy[i], 0);
      check("rst_words_sent", ws[i], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 32'h7061_7373, 1'b0);
    for (int j = 0; j < 3; j++) send(0, $urandom, 1'b0);

    // Reset in the middle of a DATA bit: partial word dropped.
    accept(0, $urandom, t);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (CPB*3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx", tx[0], 1);
    check("midrst_ready", ready[0], 1);
    check("midrst_words_sent", ws[0], 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_ws[0] = 0;
    exp_ws[1] = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(1, 32'h6661_696C, 1'b0);
    send(1, $urandom, 1'b0);
    send(0, $urandom, 1'b1);
    send(1, $urandom, 1'b1);
    burst(0, 4);
    burst(1, 3);

    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 2000) begin @(negedge clk); k++; end
      repeat (4) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Downstream consumer of the core's 32-bit ASCII status word ("pass", "fail", or a 4-digit hex PC).
- Accepts one word per valid/ready handshake and serialises its four bytes MSB-byte first over a UART 8N1 line, optionally followed by CR LF.
- Sits between the core and the board TX pin; the top level generates word_valid (e.g. on tx_word change).

Parameters:
- CLK_FREQ, 27000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- APPEND_CRLF, 1: 1 = send 0x0D, 0x0A after the four word bytes; 0 = word bytes only.
- Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 234 at defaults). Must be >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- word_in  in  32  word to send; byte0 = [31:24], byte1 = [23:16], byte2 = [15:8], byte3 = [7:0].
- word_valid  in  1  word_in is valid.
- word_ready  out  1  block can accept a word (high only in IDLE).
- uart_tx  out  1  serial line, idle high.
- busy  out  1  transmission in progress (inverse of word_ready).
- words_sent  out  16  count of fully transmitted words, wraps modulo 2^16.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-low reset rst_n. While rst_n is low at a posedge:
  - state <= IDLE; uart_tx <= 1; words_sent <= 0; baud counter, bit index and byte index <= 0.
  - Outputs after reset: word_ready = 1, busy = 0.
- Reset mid-frame: aborts immediately. uart_tx is high after that edge, the partial word is dropped and words_sent is not incremented.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - uart_tx = 1; word_ready = 1.
  - If word_valid && word_ready at a posedge: latch word_in into a shift buffer, byte_idx <= 0, state <= START.
  - uart_tx drives low from that same edge.
- START: uart_tx = 0 for exactly CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Sends 8 bits of the current byte, LSB first, each held CLKS_PER_BIT cycles; bit_idx runs 0..7.
  - After bit 7, state <= STOP.
- STOP: uart_tx = 1 for CLKS_PER_BIT cycles. Then:
  - if byte_idx < LAST (3, or 5 with APPEND_CRLF): byte_idx++, state <= START; no idle gap between bytes.
  - else: words_sent++, state <= IDLE.
- Byte sequence: byte0..byte3, then 0x0D, 0x0A when APPEND_CRLF = 1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on each bit boundary. No drift is permitted: every bit lasts exactly CLKS_PER_BIT clocks.
- Latency: word accepted at edge N → uart_tx low from edge N. The line returns to IDLE and word_ready goes high at edge N + 10*CLKS_PER_BIT*NBYTES, where NBYTES = 4 or 6.
- word_in / word_valid changes while busy are ignored; the latched copy is sent unchanged.
- The earliest next acceptance is the edge on which word_ready is first high. The minimum gap between words is 1 idle cycle, with uart_tx high during it.
- Valid asserted on the final STOP cycle: not accepted (ready is low); accepted on the following edge if still asserted.
- uart_tx is driven directly from a register; no combinational path from inputs.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles mid-DATA (CLK_FREQ=40, BAUD=10 → CPB=4) → uart_tx = 1, word_ready = 1, words_sent = 0 after the first reset edge.
- Send "pass" (0x70617373) with APPEND_CRLF=0, CPB=4:
  - bytes decode as 0x70, 0x61, 0x73, 0x73.
  - first frame is 0, 0,0,0,0,1,1,1,0, 1, each level held 4 cycles.
  - word_ready returns high 160 cycles after acceptance; words_sent = 1.
- APPEND_CRLF=1 with "fail" (0x6661696C) → 6 frames decoding 0x66, 0x61, 0x69, 0x6C, 0x0D, 0x0A in 240 cycles.
- Change word_in to 0xFFFFFFFF and pulse word_valid while busy → transmitted bytes still match the originally latched word; the second valid is not accepted.
- word_valid held high continuously → back-to-back words separated by exactly 1 idle-high cycle; words_sent increments once per word.
- Drive 65536 words (fast CPB=2) → words_sent wraps to 0.
